// File: rtl/dht_sensor_reader.sv
// Single-wire DHT11/DHT22 reader: host start pulse, response and bit-timing decode,
// checksum and field decode, per-phase timeouts and a valid/ready result port.
module dht_sensor_reader #(
    parameter int CLK_HZ             = 100_000_000,
    parameter int POWERUP_MS         = 1000,
    parameter int MIN_INTERVAL_MS    = 1000,
    parameter int START_LOW_DHT11_US = 18000,
    parameter int START_LOW_DHT22_US = 1000,
    parameter int BIT_THRESH_US      = 48,
    parameter int TIMEOUT_US         = 200,
    parameter int SYNC_STAGES        = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        sensor_type,
    input  logic        data_i,
    output logic        data_o,
    output logic        data_oe,
    output logic        busy,
    output logic        result_valid,
    input  logic        result_ready,
    output logic [15:0] humidity,
    output logic [15:0] temperature,
    output logic [39:0] raw_frame,
    output logic        crc_ok,
    output logic        err_timeout
);

    localparam int PRESCALE = (CLK_HZ / 1_000_000 > 1) ? (CLK_HZ / 1_000_000) : 1;
    localparam int PRE_W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int SYNC_N   = (SYNC_STAGES > 2) ? SYNC_STAGES : 2;

    // Durations are stored as "last count" so a phase lasts exactly N microsecond ticks.
    localparam logic [23:0] POWERUP_LAST  = 24'(POWERUP_MS * 1000 - 1);
    localparam logic [23:0] INTERVAL_LAST = 24'(MIN_INTERVAL_MS * 1000 - 1);
    localparam logic [23:0] LOW11_LAST    = 24'(START_LOW_DHT11_US - 1);
    localparam logic [23:0] LOW22_LAST    = 24'(START_LOW_DHT22_US - 1);
    localparam logic [23:0] THRESH        = 24'(BIT_THRESH_US);
    localparam logic [23:0] TIMEOUT       = 24'(TIMEOUT_US);

    typedef enum logic [3:0] {
        S_POWERUP,
        S_IDLE,
        S_START_LOW,
        S_WAIT_RESP,
        S_RESP_LOW,
        S_RESP_HIGH,
        S_BIT_LOW,
        S_BIT_HIGH,
        S_FINISH,
        S_COOLDOWN
    } state_t;

    state_t state, next_state;

    logic [PRE_W-1:0]  pre_cnt;
    logic              us_tick;
    logic [SYNC_N-1:0] sync_q;
    logic              data_s;
    logic              data_prev;
    logic              rise;
    logic              fall;
    logic [23:0]       phase_cnt;
    logic [23:0]       start_low_last;
    logic              phase_expired;
    logic              type_q;
    logic [39:0]       shift_reg;
    logic [5:0]        bit_idx;
    logic              bit_value;
    logic [39:0]       frame_next;
    logic [7:0]        b0, b1, b2, b3, b4;
    logic [7:0]        byte_sum;
    logic [15:0]       temp_mag;
    logic [15:0]       temp_dec;
    logic              accept;
    logic              shift_en;
    logic              frame_done;
    logic              timeout_hit;

    assign data_o = 1'b0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre_cnt <= '0;
            us_tick <= 1'b0;
        end else if (pre_cnt == PRE_W'(PRESCALE - 1)) begin
            pre_cnt <= '0;
            us_tick <= 1'b1;
        end else begin
            pre_cnt <= pre_cnt + PRE_W'(1);
            us_tick <= 1'b0;
        end
    end

    // Synchroniser idles high so a released bus produces no spurious edge after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q    <= '1;
            data_prev <= 1'b1;
        end else begin
            sync_q    <= {sync_q[SYNC_N-2:0], data_i};
            data_prev <= data_s;
        end
    end

    assign data_s = sync_q[SYNC_N-1];
    assign rise   = data_s & ~data_prev;
    assign fall   = ~data_s & data_prev;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_cnt <= '0;
        end else if (state != next_state) begin
            phase_cnt <= '0;
        end else if (us_tick && (phase_cnt != 24'hFF_FFFF)) begin
            phase_cnt <= phase_cnt + 24'd1;
        end
    end

    assign start_low_last = type_q ? LOW22_LAST : LOW11_LAST;
    assign phase_expired  = us_tick && (phase_cnt >= TIMEOUT);
    // The phase counter doubles as the high-pulse timer since BIT_HIGH entry clears it.
    assign bit_value      = (phase_cnt > THRESH);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_POWERUP;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state  = state;
        accept      = 1'b0;
        shift_en    = 1'b0;
        frame_done  = 1'b0;
        timeout_hit = 1'b0;
        case (state)
            S_POWERUP: begin
                if (us_tick && (phase_cnt >= POWERUP_LAST)) begin
                    next_state = S_IDLE;
                end
            end
            S_IDLE: begin
                if (start && !result_valid) begin
                    accept     = 1'b1;
                    next_state = S_START_LOW;
                end
            end
            S_START_LOW: begin
                if (us_tick && (phase_cnt >= start_low_last)) begin
                    next_state = S_WAIT_RESP;
                end
            end
            S_WAIT_RESP: begin
                if (fall) begin
                    next_state = S_RESP_LOW;
                end else if (phase_expired) begin
                    timeout_hit = 1'b1;
                    next_state  = S_COOLDOWN;
                end
            end
            S_RESP_LOW: begin
                if (rise) begin
                    next_state = S_RESP_HIGH;
                end else if (phase_expired) begin
                    timeout_hit = 1'b1;
                    next_state  = S_COOLDOWN;
                end
            end
            S_RESP_HIGH: begin
                if (fall) begin
                    next_state = S_BIT_LOW;
                end else if (phase_expired) begin
                    timeout_hit = 1'b1;
                    next_state  = S_COOLDOWN;
                end
            end
            S_BIT_LOW: begin
                if (rise) begin
                    next_state = S_BIT_HIGH;
                end else if (phase_expired) begin
                    timeout_hit = 1'b1;
                    next_state  = S_COOLDOWN;
                end
            end
            S_BIT_HIGH: begin
                if (fall) begin
                    shift_en = 1'b1;
                    if (bit_idx == 6'd39) begin
                        frame_done = 1'b1;
                        next_state = S_FINISH;
                    end else begin
                        next_state = S_BIT_LOW;
                    end
                end else if (phase_expired) begin
                    timeout_hit = 1'b1;
                    next_state  = S_COOLDOWN;
                end
            end
            S_FINISH: begin
                next_state = S_COOLDOWN;
            end
            S_COOLDOWN: begin
                if (us_tick && (phase_cnt >= INTERVAL_LAST)) begin
                    next_state = S_IDLE;
                end
            end
            default: begin
                next_state = S_POWERUP;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            type_q    <= 1'b0;
            shift_reg <= '0;
            bit_idx   <= '0;
        end else if (accept) begin
            type_q    <= sensor_type;
            shift_reg <= '0;
            bit_idx   <= '0;
        end else if (shift_en) begin
            shift_reg <= frame_next;
            bit_idx   <= bit_idx + 6'd1;
        end
    end

    // Decode from the frame including the bit being shifted in, so results land
    // one cycle after the final falling edge.
    assign frame_next           = {shift_reg[38:0], bit_value};
    assign {b0, b1, b2, b3, b4} = frame_next;
    assign byte_sum             = b0 + b1 + b2 + b3;
    assign temp_mag             = {1'b0, b2[6:0], b3};
    assign temp_dec             = type_q ? (b2[7] ? (16'd0 - temp_mag) : temp_mag)
                                         : {b2, b3};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_oe      <= 1'b0;
            busy         <= 1'b0;
            result_valid <= 1'b0;
            humidity     <= '0;
            temperature  <= '0;
            raw_frame    <= '0;
            crc_ok       <= 1'b0;
            err_timeout  <= 1'b0;
        end else begin
            data_oe <= (next_state == S_START_LOW);
            busy    <= (next_state != S_POWERUP) && (next_state != S_IDLE);
            if (frame_done) begin
                result_valid <= 1'b1;
                humidity     <= {b0, b1};
                temperature  <= temp_dec;
                raw_frame    <= frame_next;
                crc_ok       <= (byte_sum == b4);
                err_timeout  <= 1'b0;
            end else if (timeout_hit) begin
                result_valid <= 1'b1;
                humidity     <= '0;
                temperature  <= '0;
                raw_frame    <= shift_reg;
                crc_ok       <= 1'b0;
                err_timeout  <= 1'b1;
            end else if (result_valid && result_ready) begin
                result_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_dht_sensor_reader.sv
// Directed bench for dht_sensor_reader: 1 MHz clock (one microsecond per cycle)
// and a behavioural open-drain sensor model on the data line.
`timescale 1ns/1ps
module tb_dht_sensor_reader;

    localparam int US = 1000;
    localparam logic [39:0] F11_GOOD = 40'h37_00_18_00_4F;
    localparam logic [39:0] F11_BAD  = 40'h37_00_18_00_50;
    localparam logic [39:0] F22_NEG  = 40'h02_8C_80_65_73;
    localparam logic [39:0] F22_POS  = 40'h01_F4_00_FA_EF;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        sensor_type;
    logic        data_i;
    logic        data_o;
    logic        data_oe;
    logic        busy;
    logic        result_valid;
    logic        result_ready;
    logic [15:0] humidity;
    logic [15:0] temperature;
    logic [39:0] raw_frame;
    logic        crc_ok;
    logic        err_timeout;
    logic        sensor_low;

    int checks_total  = 0;
    int checks_passed = 0;

    // Pulled-up open-drain line: low when either the host or the sensor drives it.
    assign data_i = !(data_oe || sensor_low);

    always #(US / 2) clk = ~clk;

    dht_sensor_reader #(
        .CLK_HZ(1_000_000),
        .POWERUP_MS(1),
        .MIN_INTERVAL_MS(1),
        .START_LOW_DHT11_US(18000),
        .START_LOW_DHT22_US(1000),
        .BIT_THRESH_US(48),
        .TIMEOUT_US(200),
        .SYNC_STAGES(2)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .start(start),
        .sensor_type(sensor_type),
        .data_i(data_i),
        .data_o(data_o),
        .data_oe(data_oe),
        .busy(busy),
        .result_valid(result_valid),
        .result_ready(result_ready),
        .humidity(humidity),
        .temperature(temperature),
        .raw_frame(raw_frame),
        .crc_ok(crc_ok),
        .err_timeout(err_timeout)
    );

    task automatic wait_oe(input logic level, input int max_cycles, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < max_cycles; i++) begin
            @(posedge clk); #1;
            if (data_oe === level) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_valid(input int max_cycles, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < max_cycles; i++) begin
            @(posedge clk); #1;
            if (result_valid === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_idle(input int max_cycles, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < max_cycles; i++) begin
            @(posedge clk); #1;
            if (busy === 1'b0) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    // Sensor: 80/80 us response, then 50 us low + 26/70 us high per bit, then a closing low.
    task automatic sensor_reply(input logic [39:0] frame, input int nbits);
        #(30 * US);
        sensor_low = 1'b1; #(80 * US);
        sensor_low = 1'b0; #(80 * US);
        for (int i = 0; i < nbits; i++) begin
            sensor_low = 1'b1; #(50 * US);
            sensor_low = 1'b0;
            #((frame[39-i] ? 70 : 26) * US);
        end
        sensor_low = 1'b1;
        if (nbits == 40) begin
            #(50 * US);
            sensor_low = 1'b0;
        end
    endtask

    task automatic run_conversion(input logic typ, input logic [39:0] frame, input bit respond,
                                  output int low_us, output int resp_us, output bit got_valid);
        bit  ok;
        time t0;
        time t1;
        low_us    = -1;
        resp_us   = -1;
        got_valid = 1'b0;
        sensor_type = typ;
        start       = 1'b1;
        wait_oe(1'b1, 5, ok);
        start       = 1'b0;
        sensor_type = ~typ;
        if (!ok) return;
        t0 = $time;
        wait_oe(1'b0, 20000, ok);
        if (!ok) return;
        t1 = $time;
        low_us = int'((t1 - t0) / US);
        if (respond) sensor_reply(frame, 40);
        wait_valid(400, got_valid);
        if (got_valid) resp_us = int'(($time - t1) / US);
    endtask

    task automatic consume(output bit idle_ok);
        result_ready = 1'b1;
        @(posedge clk); #1;
        result_ready = 1'b0;
        wait_idle(1500, idle_ok);
    endtask

    task automatic test_reset();
        bit ok;
        rst_n = 1'b0; start = 1'b0; sensor_type = 1'b0; result_ready = 1'b0; sensor_low = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        checks_total++;
        if (data_oe !== 1'b0) $display("[TB] FAIL reset_oe: got %b expected 0", data_oe); else checks_passed++;
        checks_total++;
        if (busy !== 1'b0) $display("[TB] FAIL reset_busy: got %b expected 0", busy); else checks_passed++;
        checks_total++;
        if (result_valid !== 1'b0) $display("[TB] FAIL reset_valid: got %b expected 0", result_valid); else checks_passed++;
        checks_total++;
        if (raw_frame !== 40'h0) $display("[TB] FAIL reset_raw: got %h expected 0", raw_frame); else checks_passed++;
        checks_total++;
        if (data_o !== 1'b0) $display("[TB] FAIL reset_data_o: got %b expected 0", data_o); else checks_passed++;
        checks_total++;
        if (err_timeout !== 1'b0) $display("[TB] FAIL reset_err: got %b expected 0", err_timeout); else checks_passed++;
        rst_n = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        start = 1'b1;
        wait_oe(1'b1, 20, ok);
        start = 1'b0;
        checks_total++;
        if (ok !== 1'b0) $display("[TB] FAIL powerup_start_ignored: got oe=%b expected 0", ok); else checks_passed++;
        repeat (1000) @(posedge clk);
        #1;
    endtask

    task automatic test_dht11();
        int low_us, resp_us;
        bit got_valid, idle_ok;
        run_conversion(1'b0, F11_GOOD, 1'b1, low_us, resp_us, got_valid);
        checks_total++;
        if (got_valid !== 1'b1) $display("[TB] FAIL dht11_valid: got %b expected 1", got_valid); else checks_passed++;
        checks_total++;
        if (low_us < 17999 || low_us > 18001) $display("[TB] FAIL dht11_start_low: got %0d us expected 18000", low_us); else checks_passed++;
        checks_total++;
        if (humidity !== 16'h3700) $display("[TB] FAIL dht11_hum: got %h expected 3700", humidity); else checks_passed++;
        checks_total++;
        if (temperature !== 16'h1800) $display("[TB] FAIL dht11_temp: got %h expected 1800", temperature); else checks_passed++;
        checks_total++;
        if (crc_ok !== 1'b1) $display("[TB] FAIL dht11_crc: got %b expected 1", crc_ok); else checks_passed++;
        checks_total++;
        if (err_timeout !== 1'b0) $display("[TB] FAIL dht11_err: got %b expected 0", err_timeout); else checks_passed++;
        checks_total++;
        if (raw_frame !== F11_GOOD) $display("[TB] FAIL dht11_raw: got %h expected %h", raw_frame, F11_GOOD); else checks_passed++;
        checks_total++;
        if (busy !== 1'b1) $display("[TB] FAIL dht11_busy: got %b expected 1", busy); else checks_passed++;
        consume(idle_ok);
        checks_total++;
        if (idle_ok !== 1'b1) $display("[TB] FAIL dht11_cooldown_end: got busy-clear=%b expected 1", idle_ok); else checks_passed++;
    endtask

    task automatic test_dht22();
        int low_us, resp_us;
        bit got_valid, idle_ok;
        run_conversion(1'b1, F22_NEG, 1'b1, low_us, resp_us, got_valid);
        checks_total++;
        if (low_us < 999 || low_us > 1001) $display("[TB] FAIL dht22_start_low: got %0d us expected 1000", low_us); else checks_passed++;
        checks_total++;
        if (humidity !== 16'h028C) $display("[TB] FAIL dht22_hum: got %h expected 028c", humidity); else checks_passed++;
        checks_total++;
        if (temperature !== 16'hFF9B) $display("[TB] FAIL dht22_temp: got %h expected ff9b", temperature); else checks_passed++;
        checks_total++;
        if (crc_ok !== 1'b1) $display("[TB] FAIL dht22_crc: got %b expected 1", crc_ok); else checks_passed++;
        checks_total++;
        if (got_valid !== 1'b1 || err_timeout !== 1'b0) $display("[TB] FAIL dht22_status: got valid=%b err=%b expected 1/0", got_valid, err_timeout); else checks_passed++;
        consume(idle_ok);
    endtask

    task automatic test_bad_crc();
        int low_us, resp_us;
        bit got_valid, idle_ok;
        run_conversion(1'b0, F11_BAD, 1'b1, low_us, resp_us, got_valid);
        checks_total++;
        if (crc_ok !== 1'b0 || got_valid !== 1'b1) $display("[TB] FAIL badcrc_crc: got crc=%b valid=%b expected 0/1", crc_ok, got_valid); else checks_passed++;
        checks_total++;
        if (humidity !== 16'h3700) $display("[TB] FAIL badcrc_hum: got %h expected 3700", humidity); else checks_passed++;
        checks_total++;
        if (raw_frame !== F11_BAD) $display("[TB] FAIL badcrc_raw: got %h expected %h", raw_frame, F11_BAD); else checks_passed++;
        checks_total++;
        if (err_timeout !== 1'b0) $display("[TB] FAIL badcrc_err: got %b expected 0", err_timeout); else checks_passed++;
        consume(idle_ok);
    endtask

    task automatic test_timeout();
        int low_us, resp_us;
        bit got_valid, idle_ok;
        run_conversion(1'b1, 40'h0, 1'b0, low_us, resp_us, got_valid);
        checks_total++;
        if (got_valid !== 1'b1) $display("[TB] FAIL timeout_valid: got %b expected 1", got_valid); else checks_passed++;
        checks_total++;
        if (resp_us < 200 || resp_us > 202) $display("[TB] FAIL timeout_latency: got %0d us expected 200..202", resp_us); else checks_passed++;
        checks_total++;
        if (err_timeout !== 1'b1) $display("[TB] FAIL timeout_err: got %b expected 1", err_timeout); else checks_passed++;
        checks_total++;
        if (crc_ok !== 1'b0) $display("[TB] FAIL timeout_crc: got %b expected 0", crc_ok); else checks_passed++;
        checks_total++;
        if (humidity !== 16'h0 || temperature !== 16'h0) $display("[TB] FAIL timeout_fields: got %h/%h expected 0000/0000", humidity, temperature); else checks_passed++;
        checks_total++;
        if (raw_frame !== 40'h0) $display("[TB] FAIL timeout_raw: got %h expected 0", raw_frame); else checks_passed++;
        checks_total++;
        if (busy !== 1'b1) $display("[TB] FAIL timeout_busy: got %b expected 1", busy); else checks_passed++;
        consume(idle_ok);
        checks_total++;
        if (idle_ok !== 1'b1 || busy !== 1'b0) $display("[TB] FAIL timeout_cooldown_end: got busy=%b expected 0", busy); else checks_passed++;
    endtask

    task automatic test_back_to_back();
        int low_us, resp_us;
        bit got_valid, ok, oe_seen, changed;
        run_conversion(1'b1, F22_NEG, 1'b1, low_us, resp_us, got_valid);
        checks_total++;
        if (got_valid !== 1'b1) $display("[TB] FAIL hold_first_valid: got %b expected 1", got_valid); else checks_passed++;
        oe_seen = 1'b0;
        changed = 1'b0;
        for (int c = 0; c < 5000; c++) begin
            start = (c % 250 == 0);
            @(posedge clk); #1;
            if (data_oe !== 1'b0) oe_seen = 1'b1;
            if (humidity !== 16'h028C || temperature !== 16'hFF9B || raw_frame !== F22_NEG || result_valid !== 1'b1) changed = 1'b1;
        end
        start = 1'b0;
        checks_total++;
        if (oe_seen !== 1'b0) $display("[TB] FAIL hold_no_restart: got oe seen=%b expected 0", oe_seen); else checks_passed++;
        checks_total++;
        if (changed !== 1'b0) $display("[TB] FAIL hold_stable: got changed=%b expected 0", changed); else checks_passed++;
        checks_total++;
        if (busy !== 1'b0) $display("[TB] FAIL hold_busy: got %b expected 0", busy); else checks_passed++;
        sensor_type  = 1'b1;
        result_ready = 1'b1;
        start        = 1'b1;
        @(posedge clk); #1;
        result_ready = 1'b0;
        start        = 1'b0;
        checks_total++;
        if (result_valid !== 1'b0) $display("[TB] FAIL accept_valid_drop: got %b expected 0", result_valid); else checks_passed++;
        checks_total++;
        if (data_oe !== 1'b0) $display("[TB] FAIL accept_same_cycle_start: got oe=%b expected 0", data_oe); else checks_passed++;
        start = 1'b1;
        wait_oe(1'b1, 5, ok);
        start = 1'b0;
        checks_total++;
        if (ok !== 1'b1) $display("[TB] FAIL next_start_accepted: got %b expected 1", ok); else checks_passed++;
    endtask

    task automatic test_reset_mid_frame();
        int low_us, resp_us;
        bit ok, got_valid;
        wait_oe(1'b0, 1500, ok);
        checks_total++;
        if (ok !== 1'b1) $display("[TB] FAIL midreset_release: got %b expected 1", ok); else checks_passed++;
        sensor_reply(F22_NEG, 20);
        #(20 * US);
        rst_n = 1'b0;
        #1;
        checks_total++;
        if (busy !== 1'b0 || data_oe !== 1'b0) $display("[TB] FAIL midreset_outputs: got busy=%b oe=%b expected 0/0", busy, data_oe); else checks_passed++;
        checks_total++;
        if (result_valid !== 1'b0 || raw_frame !== 40'h0) $display("[TB] FAIL midreset_result: got valid=%b raw=%h expected 0/0", result_valid, raw_frame); else checks_passed++;
        sensor_low = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (500) @(posedge clk);
        #1;
        sensor_type = 1'b1;
        start       = 1'b1;
        wait_oe(1'b1, 5, ok);
        start       = 1'b0;
        checks_total++;
        if (ok !== 1'b0) $display("[TB] FAIL midreset_powerup_ignore: got oe=%b expected 0", ok); else checks_passed++;
        repeat (600) @(posedge clk);
        #1;
        run_conversion(1'b1, F22_POS, 1'b1, low_us, resp_us, got_valid);
        checks_total++;
        if (got_valid !== 1'b1) $display("[TB] FAIL midreset_new_valid: got %b expected 1", got_valid); else checks_passed++;
        checks_total++;
        if (humidity !== 16'h01F4 || temperature !== 16'h00FA) $display("[TB] FAIL midreset_fields: got %h/%h expected 01f4/00fa", humidity, temperature); else checks_passed++;
        checks_total++;
        if (crc_ok !== 1'b1 || raw_frame !== F22_POS) $display("[TB] FAIL midreset_frame: got crc=%b raw=%h expected 1/%h", crc_ok, raw_frame, F22_POS); else checks_passed++;
    endtask

    initial begin
        test_reset();
        test_dht11();
        test_dht22();
        test_bad_crc();
        test_timeout();
        test_back_to_back();
        test_reset_mid_frame();
        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule

// File: doc/dht_sensor_reader.md
Name: dht_sensor_reader

Overview:
Parametrised single-wire humidity/temperature sensor controller that supersedes the fixed DHT11-only reader. It supports DHT11 and DHT22 framing, selected by a port, and clock frequency is a parameter. Every bus phase has a timeout, the checksum is validated, and results are delivered through a valid/ready handshake. It sits between the open-drain sensor pad (driven via o/oe pins) and the UART/report logic.

Parameters:
CLK_HZ, 100_000_000, system clock frequency; the µs prescaler divides by CLK_HZ/1_000_000.
POWERUP_MS, 1000, wait after reset before the first conversion.
MIN_INTERVAL_MS, 1000, minimum time from one frame end to the next start pulse.
START_LOW_DHT11_US, 18000, host start-low duration in DHT11 mode.
START_LOW_DHT22_US, 1000, host start-low duration in DHT22 mode.
BIT_THRESH_US, 48, high-pulse length above which a data bit decodes as 1.
TIMEOUT_US, 200, maximum duration of any sensor-driven phase.
SYNC_STAGES, 2, input synchroniser depth (minimum 2).

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
start  in  1  conversion request, sampled one cycle
sensor_type  in  1  0=DHT11, 1=DHT22; latched when start is accepted
data_i  in  1  pad input
data_o  out  1  pad output value, constant 0
data_oe  out  1  1 = drive pad low, 0 = release
busy  out  1  conversion or cooldown in progress
result_valid  out  1  result available
result_ready  in  1  consumer accepts result
humidity  out  16  DHT11: {RH int, RH dec}; DHT22: RH ×10, unsigned
temperature  out  16  DHT11: {T int, T dec}; DHT22: T ×10, two's complement
raw_frame  out  40  received bits, first bit at [39]
crc_ok  out  1  checksum matched
err_timeout  out  1  a phase exceeded TIMEOUT_US; data fields are 0

Behaviour:
- Reset: clk and rst_n, asynchronous active-low. All outputs reset to 0. State resets to POWERUP. The synchroniser resets to 1 (idle bus high).
- Timebase: a free-running prescaler generates a 1-cycle us_tick every CLK_HZ/1e6 clocks. All durations count us_ticks, and the phase counter is 24 bits.
- Edge detection is performed on the synchronised data_i only. Input latency is SYNC_STAGES cycles.
- States:
  - POWERUP: wait POWERUP_MS, then go to IDLE.
  - IDLE: start=1 and result_valid=0 → START_LOW and busy=1. Otherwise start is ignored and not queued.
  - START_LOW: data_oe=1 for START_LOW_x_US, then data_oe=0 and go to WAIT_RESP.
  - WAIT_RESP: wait for a falling edge → RESP_LOW.
  - RESP_LOW: wait for a rising edge → RESP_HIGH.
  - RESP_HIGH: wait for a falling edge → BIT_LOW, with bit index = 0.
  - BIT_LOW: wait for a rising edge → BIT_HIGH, and clear the high counter.
  - BIT_HIGH: on a falling edge, shift in bit = (high_us > BIT_THRESH_US) and increment the index. If the index reaches 40 → FINISH, otherwise → BIT_LOW.
  - FINISH: compute outputs, set result_valid=1 (registered, 1 cycle after the last falling edge), then go to COOLDOWN.
  - COOLDOWN: wait MIN_INTERVAL_MS with busy=1, then go to IDLE with busy=0.
- Timeouts: the phase counter clears on every state change. If the counter exceeds TIMEOUT_US in WAIT_RESP, RESP_LOW, RESP_HIGH, BIT_LOW or BIT_HIGH:
  - err_timeout=1, crc_ok=0, humidity/temperature=0, raw_frame = bits so far;
  - result_valid=1, go to COOLDOWN.
- Checksum: B4 == (B0+B1+B2+B3) mod 256, where B0 = raw_frame[39:32].
- DHT22 decode:
  - humidity = {B0,B1};
  - temperature magnitude = {B2[6:0],B3}; if B2[7]=1, temperature = −magnitude (16-bit two's complement).
- DHT11 decode: fields are passed through as bytes.
- Decoding applies regardless of crc_ok. The consumer decides what to do with bad data.
- Handshake:
  - result_valid stays high, and all result fields stay stable, until the cycle where result_valid & result_ready.
  - result_valid clears on the next edge.
  - The result is held through COOLDOWN if it has not been consumed.
- Simultaneous: start on the same cycle as result acceptance is ignored, because result_valid is still 1 that cycle.
- Reset mid-operation: immediate return to POWERUP, data_oe=0 asynchronously, partial frame discarded.
- sensor_type changes while busy have no effect until the next accepted start.

Test Plan:
All scenarios use POWERUP_MS=1, MIN_INTERVAL_MS=1 and a behavioural sensor model (80/80 µs response; 50 µs low plus 26 µs or 70 µs high per bit).
- DHT11 frame 0x37,0x00,0x18,0x00,0x4F → data_oe low 18000 µs; humidity=0x3700, temperature=0x1800, crc_ok=1, err_timeout=0.
- DHT22 frame 0x02,0x8C,0x80,0x65,0x73 → data_oe low 1000 µs; humidity=0x028C, temperature=0xFF9B (−10.1 °C), crc_ok=1.
- DHT11 frame with checksum 0x50 instead of 0x4F → crc_ok=0, humidity=0x3700, raw_frame=0x3700180050.
- Sensor silent after release → err_timeout=1 and result_valid exactly TIMEOUT_US+overhead (≤202 µs) after data_oe falls; busy=0 after the cooldown.
- result_ready held 0 for 5000 cycles with start pulsed repeatedly → no new data_oe assertion, fields stable; after ready=1, result_valid drops next cycle and the next start is accepted.
- rst_n asserted during bit 20 → data_oe=0 and busy=0 at once; the next start succeeds only after POWERUP_MS.
